// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter for a single-ported memory.
// Each transaction walks IDLE -> ACCESS -> RESP; all outputs are registered.
module mem_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             we0,
  input  logic [WIDTH-1:0] adr0,
  input  logic [WIDTH-1:0] wd0,
  output logic             gnt0,
  output logic             done0,
  output logic [WIDTH-1:0] rd0,
  input  logic             req1,
  input  logic             we1,
  input  logic [WIDTH-1:0] adr1,
  input  logic [WIDTH-1:0] wd1,
  output logic             gnt1,
  output logic             done1,
  output logic [WIDTH-1:0] rd1,
  output logic             memread,
  output logic             memwrite,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] memdata,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic last, owner, we_l, sel, sel_we;
  // On a tie the port that was not served last wins.
  assign sel = (req0 && req1) ? ~last : req1;
  assign sel_we = sel ? we1 : we0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      we_l      <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rd0       <= '0;
      rd1       <= '0;
      cnt0      <= '0;
      cnt1      <= '0;
      memread   <= 1'b0;
      memwrite  <= 1'b0;
      adr       <= '0;
      writedata <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: if (req0 || req1) begin
          owner     <= sel;
          we_l      <= sel_we;
          adr       <= sel ? adr1 : adr0;
          writedata <= sel ? wd1 : wd0;
          memread   <= ~sel_we;
          memwrite  <= sel_we;
          gnt0      <= ~sel;
          gnt1      <= sel;
          state     <= ACCESS;
        end
        ACCESS: begin
          gnt0     <= 1'b0;
          gnt1     <= 1'b0;
          memread  <= 1'b0;
          memwrite <= 1'b0;
          state    <= RESP;
        end
        RESP: begin
          if (!we_l && !owner) rd0 <= memdata;
          if (!we_l && owner) rd1 <= memdata;
          done0 <= ~owner;
          done1 <= owner;
          cnt0  <= cnt0 + {7'd0, ~owner};
          cnt1  <= cnt1 + {7'd0, owner};
          last  <= owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests for mem_arbiter against a small memory model.
module tb_mem_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [7:0] adr0 = '0, wd0 = '0, adr1 = '0, wd1 = '0;
  logic       gnt0, done0, gnt1, done1, memread, memwrite;
  logic [7:0] rd0, rd1, adr, writedata, cnt0, cnt1;
  logic [7:0] memdata = '0;
  logic [7:0] mem [256];
  logic       ld = 1'b0;
  logic [7:0] ld_adr = '0, ld_dat = '0;
  int tests = 0;
  int fails = 0;

  mem_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .adr0(adr0), .wd0(wd0), .gnt0(gnt0), .done0(done0), .rd0(rd0),
    .req1(req1), .we1(we1), .adr1(adr1), .wd1(wd1), .gnt1(gnt1), .done1(done1), .rd1(rd1),
    .memread(memread), .memwrite(memwrite), .adr(adr), .writedata(writedata),
    .memdata(memdata), .cnt0(cnt0), .cnt1(cnt1)
  );

  always #5 clk = ~clk;

  // Memory model: read data appears the cycle after memread; ld preloads words.
  always @(posedge clk) begin
    if (memread) memdata <= mem[adr];
    if (memwrite) mem[adr] <= writedata;
    else if (ld) mem[ld_adr] <= ld_dat;
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); ld = 1'b1; ld_adr = a; ld_dat = d;
    @(negedge clk); ld = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); req0 = 1'b0; req1 = 1'b0; reset = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({gnt0, gnt1, done0, done1, memread, memwrite} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 000000", {gnt0, gnt1, done0, done1, memread, memwrite});
    end
    tests++;
    if ({rd0, rd1, cnt0, cnt1, adr, writedata} !== 48'h0) begin
      fails++; $display("FAIL reset_data: got %h want 0", {rd0, rd1, cnt0, cnt1, adr, writedata});
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_idle();
    int bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (memread || memwrite || gnt0 || gnt1) bad++;
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL idle_strobes: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_single_read();
    poke(8'h4C, 8'h07);
    @(negedge clk); req0 = 1'b1; we0 = 1'b0; adr0 = 8'h4C;
    @(negedge clk);
    tests++;
    if ({memread, memwrite, gnt0, gnt1} !== 4'b1010 || adr !== 8'h4C) begin
      fails++; $display("FAIL read_access: strobes %b adr %h want 1010 4c", {memread, memwrite, gnt0, gnt1}, adr);
    end
    @(negedge clk);
    tests++;
    if ({memread, gnt0, done0} !== 3'b000) begin
      fails++; $display("FAIL read_resp: got %b want 000", {memread, gnt0, done0});
    end
    @(negedge clk);
    tests++;
    if (done0 !== 1'b1 || rd0 !== 8'h07 || cnt0 !== 8'd1) begin
      fails++; $display("FAIL read_done: done0 %b rd0 %h cnt0 %0d want 1 07 1", done0, rd0, cnt0);
    end
    req0 = 1'b0;
    @(negedge clk);
    tests++;
    if ({done0, gnt0, memread} !== 3'b000 || rd0 !== 8'h07) begin
      fails++; $display("FAIL read_after: ctl %b rd0 %h want 000 07", {done0, gnt0, memread}, rd0);
    end
  endtask

  task automatic test_single_write();
    @(negedge clk); req1 = 1'b1; we1 = 1'b1; adr1 = 8'h10; wd1 = 8'hA5;
    @(negedge clk);
    tests++;
    if ({memread, memwrite, gnt0, gnt1} !== 4'b0101 || adr !== 8'h10 || writedata !== 8'hA5) begin
      fails++; $display("FAIL write_access: strobes %b adr %h wd %h want 0101 10 a5", {memread, memwrite, gnt0, gnt1}, adr, writedata);
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (done1 !== 1'b1 || done0 !== 1'b0 || cnt1 !== 8'd1 || cnt0 !== 8'd1) begin
      fails++; $display("FAIL write_done: done1 %b done0 %b cnt1 %0d cnt0 %0d want 1 0 1 1", done1, done0, cnt1, cnt0);
    end
    req1 = 1'b0;
    tests++;
    if (mem[8'h10] !== 8'hA5) begin fails++; $display("FAIL write_mem: got %h want a5", mem[8'h10]); end
  endtask

  task automatic test_tie();
    int n = 0;
    int bad = 0;
    logic [3:0] seq = '0;
    do_reset();
    @(negedge clk); req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; adr0 = 8'h01; adr1 = 8'h02;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (memread && memwrite) bad++;
      if (gnt0 || gnt1) begin
        if (n < 4) seq[3 - n] = gnt1;
        n++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    tests++;
    if (n !== 4 || seq !== 4'b0101) begin fails++; $display("FAIL tie_order: grants %0d order %b want 4 0101", n, seq); end
    tests++;
    if (cnt0 !== 8'd2 || cnt1 !== 8'd2) begin fails++; $display("FAIL tie_counts: cnt0 %0d cnt1 %0d want 2 2", cnt0, cnt1); end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL tie_exclusive: got %0d overlap cycles want 0", bad); end
  endtask

  task automatic test_mid_change();
    do_reset();
    poke(8'h20, 8'h11);
    poke(8'h30, 8'h22);
    @(negedge clk); req0 = 1'b1; we0 = 1'b0; adr0 = 8'h20;
    @(negedge clk); adr0 = 8'h30;
    @(negedge clk);
    tests++;
    if (adr !== 8'h20) begin fails++; $display("FAIL mid_adr: got %h want 20", adr); end
    @(negedge clk);
    tests++;
    if (done0 !== 1'b1 || rd0 !== 8'h11) begin fails++; $display("FAIL mid_data: done0 %b rd0 %h want 1 11", done0, rd0); end
    req0 = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk); req0 = 1'b1; we0 = 1'b0; adr0 = 8'h4C;
    @(negedge clk);
    tests++;
    if (memread !== 1'b1) begin fails++; $display("FAIL rstmid_pre: memread %b want 1", memread); end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (memread !== 1'b0 || gnt0 !== 1'b0) begin fails++; $display("FAIL rstmid_async: memread %b gnt0 %b want 0 0", memread, gnt0); end
    @(negedge clk); req0 = 1'b0;
    tests++;
    if (done0 !== 1'b0 || cnt0 !== 8'd0) begin fails++; $display("FAIL rstmid_discard: done0 %b cnt0 %0d want 0 0", done0, cnt0); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); req0 = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (done0 !== 1'b1 || cnt0 !== 8'd1 || rd0 !== 8'h07) begin
      fails++; $display("FAIL rstmid_fresh: done0 %b cnt0 %0d rd0 %h want 1 1 07", done0, cnt0, rd0);
    end
    req0 = 1'b0;
  endtask

  task automatic test_counter_wrap();
    int n = 0;
    int cyc = 0;
    logic [7:0] c255 = '0;
    do_reset();
    @(negedge clk); req0 = 1'b1; we0 = 1'b0; adr0 = 8'h00;
    while (n < 256 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (done0) begin
        n++;
        if (n == 255) c255 = cnt0;
      end
    end
    req0 = 1'b0;
    tests++;
    if (n !== 256 || cyc !== 768) begin fails++; $display("FAIL wrap_timing: %0d dones in %0d cycles want 256 in 768", n, cyc); end
    tests++;
    if (c255 !== 8'd255) begin fails++; $display("FAIL wrap_255: got %0d want 255", c255); end
    tests++;
    if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin fails++; $display("FAIL wrap_zero: cnt0 %0d cnt1 %0d want 0 0", cnt0, cnt1); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_read();
    test_single_write();
    test_tie();
    test_mid_change();
    test_reset_mid();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
